// File: rtl/prbs_pkg.sv
// Shared constants, state encoding and LFSR step for the PRBS checker slice.
package prbs_pkg;

  localparam int unsigned LFSR_W         = 32;
  localparam int unsigned FILL_W         = 6;
  localparam int unsigned LANES_DEF      = 4;
  localparam int unsigned CNT_W_DEF      = 16;
  localparam int unsigned ERR_THRESH_DEF = 8;
  localparam int unsigned WIN_LEN_DEF    = 32;

  // Feedback taps at bits 31, 6, 5 and 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 32'h8000_0062;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } lane_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Data/status bundle between a PRBS source and the checker.
interface prbs_checker_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
);
  logic                   in_valid;
  logic [LANES-1:0]       in_bits;
  logic [LANES-1:0]       locked;
  logic [LANES-1:0]       err_pulse;
  logic [LANES*CNT_W-1:0] err_count;

  modport master (output in_valid, in_bits, input locked, err_pulse, err_count);
  modport slave  (input in_valid, in_bits, output locked, err_pulse, err_count);
endinterface

// File: rtl/prbs_lane_chk.sv
// One-lane PRBS checker: HUNT fills a shadow LFSR, LOCKED flywheels and counts errors.
// Window auto-resync logic exists only when PRBS_CHK_AUTORESYNC_EN is defined.
module prbs_lane_chk
  import prbs_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned ERR_THRESH = ERR_THRESH_DEF,
  parameter int unsigned WIN_LEN    = WIN_LEN_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             i_valid,
  input  logic             i_bit,
  output logic             o_locked,
  output logic             o_err_pulse,
  output logic [CNT_W-1:0] o_err_count
);

  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(LFSR_W - 1);

  if (ERR_THRESH == 0 || WIN_LEN == 0) begin : g_bad_param
    $error("prbs_lane_chk: ERR_THRESH and WIN_LEN must be non-zero");
  end

  lane_state_e       r_state, w_state_nx;
  logic [LFSR_W-1:0] r_shadow, w_shadow_nx;
  logic [FILL_W-1:0] r_fill, w_fill_nx;
  logic              r_err_pulse, w_err_pulse_nx;
  logic [CNT_W-1:0]  r_err_count, w_err_count_nx;
  logic [LFSR_W-1:0] w_lfsr_nx;
  logic [LFSR_W-1:0] w_shift;
  logic              w_mismatch;

`ifdef PRBS_CHK_AUTORESYNC_EN
  localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int unsigned ERR_W = $clog2(ERR_THRESH + 1);

  logic [WIN_W-1:0] r_win_cnt, w_win_cnt_nx;
  logic [ERR_W-1:0] r_win_err, w_win_err_nx, w_win_err_inc;
`endif

  assign w_lfsr_nx  = lfsr_next(r_shadow);
  assign w_shift    = {r_shadow[LFSR_W-2:0], i_bit};
  assign w_mismatch = i_bit ^ w_lfsr_nx[0];

  // Next-state and datapath; clear beats in_valid and drops that cycle's bit
  always_comb begin
    w_state_nx     = r_state;
    w_shadow_nx    = r_shadow;
    w_fill_nx      = r_fill;
    w_err_pulse_nx = 1'b0;
    w_err_count_nx = r_err_count;
`ifdef PRBS_CHK_AUTORESYNC_EN
    w_win_cnt_nx   = r_win_cnt;
    w_win_err_nx   = r_win_err;
    w_win_err_inc  = r_win_err + ERR_W'(w_mismatch);
`endif
    if (clear) begin
      w_state_nx     = HUNT;
      w_shadow_nx    = '0;
      w_fill_nx      = '0;
      w_err_count_nx = '0;
`ifdef PRBS_CHK_AUTORESYNC_EN
      w_win_cnt_nx   = '0;
      w_win_err_nx   = '0;
`endif
    end else if (i_valid) begin
      case (r_state)
        HUNT: begin
          w_shadow_nx = w_shift;
          if (r_fill == FILL_LAST) begin
            w_fill_nx = '0;
            // An all-zero shadow is the LFSR lock-up state; keep hunting
            if (w_shift != '0) begin
              w_state_nx = LOCKED;
`ifdef PRBS_CHK_AUTORESYNC_EN
              w_win_cnt_nx = '0;
              w_win_err_nx = '0;
`endif
            end
          end else begin
            w_fill_nx = r_fill + FILL_W'(1);
          end
        end
        LOCKED: begin
          w_shadow_nx = w_lfsr_nx;
          if (w_mismatch) begin
            w_err_pulse_nx = 1'b1;
            if (r_err_count != CNT_MAX) begin
              w_err_count_nx = r_err_count + CNT_W'(1);
            end
          end
`ifdef PRBS_CHK_AUTORESYNC_EN
          if (w_win_err_inc == ERR_W'(ERR_THRESH)) begin
            w_state_nx   = HUNT;
            w_fill_nx    = '0;
            w_win_cnt_nx = '0;
            w_win_err_nx = '0;
          end else if (r_win_cnt == WIN_W'(WIN_LEN - 1)) begin
            w_win_cnt_nx = '0;
            w_win_err_nx = '0;
          end else begin
            w_win_cnt_nx = r_win_cnt + WIN_W'(1);
            w_win_err_nx = w_win_err_inc;
          end
`endif
        end
        default: w_state_nx = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= HUNT;
      r_shadow    <= '0;
      r_fill      <= '0;
      r_err_pulse <= 1'b0;
      r_err_count <= '0;
`ifdef PRBS_CHK_AUTORESYNC_EN
      r_win_cnt   <= '0;
      r_win_err   <= '0;
`endif
    end else begin
      r_state     <= w_state_nx;
      r_shadow    <= w_shadow_nx;
      r_fill      <= w_fill_nx;
      r_err_pulse <= w_err_pulse_nx;
      r_err_count <= w_err_count_nx;
`ifdef PRBS_CHK_AUTORESYNC_EN
      r_win_cnt   <= w_win_cnt_nx;
      r_win_err   <= w_win_err_nx;
`endif
    end
  end

  assign o_locked    = (r_state == LOCKED);
  assign o_err_pulse = r_err_pulse;
  assign o_err_count = r_err_count;

endmodule

// File: rtl/prbs_checker.sv
// Multi-lane PRBS checker top: fans the bus out to LANES independent lane checkers.
// Optional window auto-resync: define PRBS_CHK_AUTORESYNC_EN.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LANES      = LANES_DEF,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned ERR_THRESH = ERR_THRESH_DEF,
  parameter int unsigned WIN_LEN    = WIN_LEN_DEF
) (
  input logic           clock,
  input logic           reset,
  input logic           clear,
  prbs_checker_if.slave io
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    prbs_lane_chk #(
      .CNT_W      (CNT_W),
      .ERR_THRESH (ERR_THRESH),
      .WIN_LEN    (WIN_LEN)
    ) u_lane (
      .clock       (clock),
      .reset       (reset),
      .clear       (clear),
      .i_valid     (io.in_valid),
      .i_bit       (io.in_bits[gi]),
      .o_locked    (io.locked[gi]),
      .o_err_pulse (io.err_pulse[gi]),
      .o_err_count (io.err_count[gi*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: two DUTs (16-bit and 2-bit counters) share one stimulus
// and are compared every cycle against a bit-history reference model.
module tb_prbs_checker;

  localparam int unsigned LANES      = 4;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned CNT_W_S    = 2;
  localparam int unsigned SAT_S      = (1 << CNT_W_S) - 1;
  localparam int unsigned ERR_THRESH = 8;
  localparam int unsigned WIN_LEN    = 32;

  logic clock = 1'b0;
  logic reset;
  logic clear;

  always #5 clock = ~clock;

  prbs_checker_if #(.LANES(LANES), .CNT_W(CNT_W))   io_a ();
  prbs_checker_if #(.LANES(LANES), .CNT_W(CNT_W_S)) io_b ();

  prbs_checker #(.LANES(LANES), .CNT_W(CNT_W), .ERR_THRESH(ERR_THRESH), .WIN_LEN(WIN_LEN)) u_dut (
    .clock (clock), .reset (reset), .clear (clear), .io (io_a)
  );
  prbs_checker #(.LANES(LANES), .CNT_W(CNT_W_S), .ERR_THRESH(ERR_THRESH), .WIN_LEN(WIN_LEN)) u_dut_s (
    .clock (clock), .reset (reset), .clear (clear), .io (io_b)
  );

  // Reference model: each lane keeps the last 32 bits of its sequence in a queue
  bit               m_lock [LANES];
  bit               m_hist [LANES][$];
  int               m_fill [LANES];
  int unsigned      m_cnt  [LANES];
`ifdef PRBS_CHK_AUTORESYNC_EN
  int               m_wpos [LANES];
  int               m_werr [LANES];
`endif
  logic [LANES-1:0] e_pulse;
  logic [31:0]      tx_state [LANES];

  int n_checks;
  int n_errors;

  typedef struct {
    logic             clr;
    logic             v;
    logic [LANES-1:0] bits;
    logic [LANES-1:0] exp_locked;
    logic [LANES-1:0] exp_pulse;
  } vec_t;
  vec_t tbl [48];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset_lane(input int l);
    m_lock[l] = 1'b0;
    m_hist[l].delete();
    m_fill[l] = 0;
    m_cnt[l]  = 0;
`ifdef PRBS_CHK_AUTORESYNC_EN
    m_wpos[l] = 0;
    m_werr[l] = 0;
`endif
  endtask

  task automatic model_reset();
    for (int l = 0; l < LANES; l++) model_reset_lane(l);
    e_pulse = '0;
  endtask

  task automatic model_step(input logic clr, input logic v, input logic [LANES-1:0] b);
    bit pred;
    bit nz;
    e_pulse = '0;
    for (int l = 0; l < LANES; l++) begin
      if (clr) begin
        model_reset_lane(l);
      end else if (v) begin
        if (!m_lock[l]) begin
          m_hist[l].push_back(b[l]);
          if (m_hist[l].size() > 32) void'(m_hist[l].pop_front());
          m_fill[l]++;
          if (m_fill[l] == 32) begin
            m_fill[l] = 0;
            nz = 1'b0;
            for (int k = 0; k < m_hist[l].size(); k++) if (m_hist[l][k]) nz = 1'b1;
            if (nz) begin
              m_lock[l] = 1'b1;
`ifdef PRBS_CHK_AUTORESYNC_EN
              m_wpos[l] = 0;
              m_werr[l] = 0;
`endif
            end
          end
        end else begin
          // x[n] = x[n-32] ^ x[n-7] ^ x[n-6] ^ x[n-2]
          pred = m_hist[l][0] ^ m_hist[l][25] ^ m_hist[l][26] ^ m_hist[l][30];
          m_hist[l].push_back(pred);
          void'(m_hist[l].pop_front());
          if (b[l] != pred) begin
            e_pulse[l] = 1'b1;
            if (m_cnt[l] < 65535) m_cnt[l]++;
`ifdef PRBS_CHK_AUTORESYNC_EN
            m_werr[l]++;
`endif
          end
`ifdef PRBS_CHK_AUTORESYNC_EN
          if (m_werr[l] == ERR_THRESH) begin
            m_lock[l] = 1'b0;
            m_hist[l].delete();
            m_fill[l] = 0;
          end else begin
            m_wpos[l]++;
            if (m_wpos[l] == WIN_LEN) begin
              m_wpos[l] = 0;
              m_werr[l] = 0;
            end
          end
`endif
        end
      end
    end
  endtask

  task automatic check_all();
    logic [LANES-1:0]         el;
    logic [LANES*CNT_W-1:0]   ea;
    logic [LANES*CNT_W_S-1:0] eb;
    for (int l = 0; l < LANES; l++) begin
      el[l] = m_lock[l];
      ea[l*CNT_W +: CNT_W] = CNT_W'(m_cnt[l]);
      eb[l*CNT_W_S +: CNT_W_S] = (m_cnt[l] > SAT_S) ? CNT_W_S'(SAT_S) : CNT_W_S'(m_cnt[l]);
    end
    check("cycle_model",
          {io_a.locked, io_a.err_pulse, io_a.err_count, io_b.locked, io_b.err_pulse, io_b.err_count},
          {el, e_pulse, ea, el, e_pulse, eb});
  endtask

  // Transmit side: the LFSR exactly as written, emitted bit is next[0]
  task automatic tx_bits(output logic [LANES-1:0] r);
    for (int l = 0; l < LANES; l++) begin
      tx_state[l] = {tx_state[l][30:0], tx_state[l][31] ^ tx_state[l][6] ^ tx_state[l][5] ^ tx_state[l][1]};
      r[l] = tx_state[l][0];
    end
  endtask

  task automatic tick(input logic clr, input logic v, input logic [LANES-1:0] b);
    clear         = clr;
    io_a.in_valid = v;
    io_a.in_bits  = b;
    io_b.in_valid = v;
    io_b.in_bits  = b;
    @(posedge clock);
    model_step(clr, v, b);
    #1;
    check_all();
  endtask

  task automatic lock_all(input string tag);
    logic [LANES-1:0] b;
    for (int k = 1; k <= 32; k++) begin
      tx_bits(b);
      tick(1'b0, 1'b1, b);
      if (k >= 31) check($sformatf("%s_k%0d", tag, k), io_a.locked, (k == 32) ? 4'hF : 4'h0);
    end
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANES-1:0] b;
    int pulses;
    int rate;
    logic clr;
    logic v;

    n_checks = 0;
    n_errors = 0;
    clear = 1'b0;
    io_a.in_valid = 1'b0; io_a.in_bits = '0;
    io_b.in_valid = 1'b0; io_b.in_bits = '0;
    tx_state[0] = 32'hAEAF696C;
    tx_state[1] = 32'h1234_5678;
    tx_state[2] = 32'hDEAD_BEEF;
    tx_state[3] = 32'h0BAD_F00D;

    reset = 1'b1;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_outputs", {io_a.locked, io_a.err_pulse, io_a.err_count, io_b.err_count}, 128'h0);
    reset = 1'b0;

    // All-zero rejection with interleaved invalid all-ones cycles
    for (int i = 0; i < 48; i++) begin
      tbl[i].clr        = 1'b0;
      tbl[i].v          = (i % 6) != 5;
      tbl[i].bits       = tbl[i].v ? 4'h0 : 4'hF;
      tbl[i].exp_locked = 4'h0;
      tbl[i].exp_pulse  = 4'h0;
    end
    for (int i = 0; i < 48; i++) begin
      tick(tbl[i].clr, tbl[i].v, tbl[i].bits);
      check($sformatf("zero_vec%0d", i), {io_a.locked, io_a.err_pulse}, {tbl[i].exp_locked, tbl[i].exp_pulse});
    end

    // Lock from seed, then 10000 clean bits
    tick(1'b1, 1'b0, '0);
    lock_all("seed_lock");
    pulses = 0;
    for (int i = 0; i < 10000; i++) begin
      tx_bits(b);
      tick(1'b0, 1'b1, b);
      pulses += int'(io_a.err_pulse[0]);
    end
    check("clean_lane0_pulses", 128'(pulses), 128'h0);
    check("clean_lane0_count", io_a.err_count[0 +: CNT_W], 128'h0);

    // Single inverted bit on lane 2
    for (int k = 1; k <= 100; k++) begin
      tx_bits(b);
      if (k == 100) b[2] = ~b[2];
      tick(1'b0, 1'b1, b);
    end
    check("err100_pulse", io_a.err_pulse, 4'b0100);
    tx_bits(b);
    tick(1'b0, 1'b1, b);
    check("err100_one_cycle", io_a.err_pulse, 4'b0000);
    check("err100_counts", io_a.err_count, 64'h0000_0001_0000_0000);
    check("err100_locked", io_a.locked, 4'hF);

    // Sparse valid while locked
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      if (i % 3 == 0) begin
        tx_bits(b);
        tick(1'b0, 1'b1, b);
      end else begin
        tick(1'b0, 1'b0, LANES'($urandom));
      end
      pulses += int'(io_a.err_pulse != 0);
    end
    check("sparse_no_pulse", 128'(pulses), 128'h0);

    // Clear together with valid: that bit is discarded
    tx_bits(b);
    tick(1'b1, 1'b1, b);
    check("clear_state", {io_a.locked, io_a.err_pulse, io_a.err_count}, 128'h0);
    lock_all("clear_relock");

    // Eight errors in one window on lane 3
    for (int k = 1; k <= 47; k++) begin
      tx_bits(b);
      if (k <= 15 && (k % 2) == 1) b[3] = ~b[3];
      tick(1'b0, 1'b1, b);
      if (k == 15) begin
        check("burst_count", io_a.err_count[3*CNT_W +: CNT_W], 128'd8);
`ifdef PRBS_CHK_AUTORESYNC_EN
        check("burst_resync", io_a.locked, 4'b0111);
`else
        check("burst_stay", io_a.locked, 4'b1111);
`endif
      end
`ifdef PRBS_CHK_AUTORESYNC_EN
      if (k == 46) check("burst_relock_k46", io_a.locked[3], 128'h0);
`endif
      if (k == 47) check("burst_final_lock", io_a.locked, 4'hF);
    end

    // Saturation on the narrow counter, plus simultaneous errors
    for (int k = 1; k <= 8; k++) begin
      tx_bits(b);
      if ((k % 2) == 1) b[1] = ~b[1];
      if (k == 7) b[0] = ~b[0];
      tick(1'b0, 1'b1, b);
      if (k == 3) check("sat_near_max", io_b.err_count[1*CNT_W_S +: CNT_W_S], 128'd2);
      if (k == 5) check("sat_reach_max", io_b.err_count[1*CNT_W_S +: CNT_W_S], 128'd3);
      if (k == 7) begin
        check("sat_hold_max", io_b.err_count[1*CNT_W_S +: CNT_W_S], 128'd3);
        check("multi_lane_pulse", io_a.err_pulse, 4'b0011);
        check("wide_count_lane1", io_a.err_count[1*CNT_W +: CNT_W], 128'd4);
      end
    end

    // Randomized traffic with rare clears and occasional error bursts
    for (int i = 0; i < 3000; i++) begin
      rate = (((i / 250) % 4) == 3) ? 30 : 2;
      clr  = ($urandom_range(0, 999) < 2);
      v    = ($urandom_range(0, 9) < 7);
      if (v) tx_bits(b);
      else   b = LANES'($urandom);
      for (int l = 0; l < LANES; l++) begin
        if (v && $urandom_range(0, 99) < rate) b[l] = ~b[l];
      end
      tick(clr, v, b);
    end

    // Asynchronous reset mid-cycle while an error pulse is showing
    tick(1'b1, 1'b0, '0);
    lock_all("pre_reset_lock");
    tx_bits(b);
    b[0] = ~b[0];
    tick(1'b0, 1'b1, b);
    check("pre_reset_pulse", io_a.err_pulse, 4'b0001);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", {io_a.locked, io_a.err_pulse, io_a.err_count, io_b.locked, io_b.err_pulse, io_b.err_count}, 128'h0);
    model_reset();
    #2;
    reset = 1'b0;
    lock_all("post_reset_lock");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 SHALL have parameter LANES, default 4: number of independent bit lanes checked.
REQ-002 SHALL have parameter CNT_W, default 16: width of each per-lane error counter.
REQ-003 SHALL have parameter ERR_THRESH, default 8: errors per window that force resync (REQ-020).
REQ-004 SHALL have parameter WIN_LEN, default 32: resync window length, in valid bits.
REQ-005 SHALL have port clock  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port clear  input  1  synchronous clear: counters to 0, all lanes to HUNT.
REQ-008 SHALL have port in_valid  input  1  in_bits qualifier; one bit per lane is consumed when high.
REQ-009 SHALL have port in_bits  input  LANES  received bit, lane i on bit i.
REQ-010 SHALL have port locked  output  LANES  lane i is in LOCKED.
REQ-011 SHALL have port err_pulse  output  LANES  one-cycle mismatch flag per lane.
REQ-012 SHALL have port err_count  output  LANES*CNT_W  per-lane saturating error counts, lane i at [i*CNT_W +: CNT_W].

Function
REQ-013 SHALL model each lane as a 32-bit Fibonacci LFSR: next = {s[30:0], s[31]^s[6]^s[5]^s[1]}; the emitted bit is next[0].
REQ-014 SHALL run, per lane, a two-state FSM {HUNT, LOCKED}; no state or counter SHALL change on cycles with in_valid low.
REQ-015 In HUNT, each valid bit SHALL shift into the lane's 32-bit shadow register at bit 0, and a 6-bit fill counter SHALL increment.
REQ-016 When a valid bit brings the fill count to 32: if the shadow is non-zero, the lane SHALL go to LOCKED on that edge; if the shadow is all-zero, the lane SHALL stay in HUNT with the fill count reset to 0.
REQ-017 In LOCKED, on each valid bit the lane SHALL compute expected = next[0] from its local state, load next (flywheel: the received bit is never loaded), and set err_pulse[i] on the following edge if in_bits[i] != expected.
REQ-018 err_pulse SHALL be registered: high for exactly the one cycle after the offending valid bit, otherwise 0.
REQ-019 err_count lane i SHALL increment by 1 per mismatch and saturate at 2^CNT_W-1; HUNT-state bits SHALL never count as errors.
REQ-020 The window counter SHALL count LOCKED valid bits modulo WIN_LEN; the window error count SHALL reset to 0 at each wrap and whenever the lane enters LOCKED.
REQ-021 clear SHALL take priority over in_valid on the same cycle; that cycle's bit SHALL be discarded.
REQ-022 Lanes SHALL be fully independent; simultaneous errors on several lanes SHALL each be counted.

Reset
REQ-023 While reset is high: all lanes in HUNT, shadow and fill count 0, locked 0, err_pulse 0, err_count 0, window counters 0.
REQ-024 Reset asserted mid-operation SHALL take effect immediately (asynchronously); the first valid bit after deassertion SHALL be fill bit 1 of HUNT.

Configuration
REQ-025 With PRBS_CHK_AUTORESYNC_EN defined, a lane whose window error count reaches ERR_THRESH SHALL return to HUNT on that edge with fill count 0; err_count SHALL be retained.
REQ-026 With PRBS_CHK_AUTORESYNC_EN undefined, a lane SHALL leave LOCKED only via reset or clear, and the window logic SHALL not be synthesised.

Structure
REQ-027 The polynomial tap constants, the HUNT/LOCKED state encoding and the default parameter values SHALL live in shared package prbs_pkg.
REQ-028 Per-lane logic SHALL be one sub-module, prbs_lane_chk, instantiated LANES times via generate; the top level SHALL only fan out ports and pack err_count.

Verification
REQ-029 Drive lane 0 from a model LFSR seeded 32'hAEAF696C with in_valid held high -> locked[0] rises 1 cycle after the 32nd bit; no err_pulse over 10000 bits; err_count lane 0 = 0.
REQ-030 After lock, invert bit 100 of lane 2 -> err_pulse[2] high for exactly one cycle, 1 cycle after that bit; count lane 2 = 1; other lanes unaffected.
REQ-031 Feed 40 zero bits -> lane stays in HUNT and locked = 0 throughout (all-zero rejection).
REQ-032 With the macro defined, inject 8 errors within one 32-bit window -> lane returns to HUNT, count = 8, and it relocks 32 clean bits later; with the macro undefined -> lane stays LOCKED, count = 8.
REQ-033 Toggle in_valid 1-in-3 while locked -> no false errors; assert clear together with in_valid -> counts 0, all lanes in HUNT, the bit on that cycle discarded.
REQ-034 Force counter to 16'hFFFE and inject 3 errors -> count holds at 16'hFFFF; asynchronous reset mid-window clears all outputs within the same cycle.
